rr_token_arbiter: RTL
=====================

Name: rr_token_arbiter

Overview:
Round-robin arbiter that shares one resource among N requesting clients using a req/ack four-phase handshake.
- Exactly one client may own the resource at a time.
- The search pointer moves past the last owner on release, so arbitration is fair.
- Sits between the client request wires and the shared resource; replaces per-client token passing with a single centralised FSM.

Parameters:
- N, 7, number of clients (2..16).
- ID_W, 3, width of the client index; must satisfy 2**ID_W >= N.
- MAX_HOLD, 15, maximum BUSY cycles before forced revoke (used only when HOLD_TIMEOUT_EN is defined).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-client request; stays high until the client is done.
- ack  output  N  per-client grant; registered, at most one bit set (one-hot or zero).
- sel  output  ID_W  index of the current owner; 0 when active=0.
- active  output  1  high while state is READY or BUSY.
- grant_cnt  output  8  count of completed grants; saturates at 255.
- revoked  output  N  sticky per-client revoke flags (held 0 when HOLD_TIMEOUT_EN is undefined).

Behaviour:
- Reset (asynchronous; on deassertion the block resumes in SCAN):
  - state=SCAN, ptr=0, owner=0.
  - ack=0, sel=0, active=0, grant_cnt=0, revoked=0, hold_cnt=0.
  - Reset asserted mid-grant drops ack immediately. No handshake completion is owed.
- States (arb_state_t): SCAN, READY, BUSY.
- SCAN:
  - Pick the first client i with eligible bit set, searching from ptr upward and wrapping N-1 to 0.
  - eligible = req & ~revoked.
  - If found: owner<=i, state<=READY.
  - If none: stay in SCAN, ptr unchanged.
  - A client at ptr wins over any other simultaneous requester.
- READY: ack[owner]<=1, hold_cnt<=0, state<=BUSY. Unconditional, one cycle.
- BUSY:
  - If req[owner]==0: ack[owner]<=0, ptr<=(owner==N-1)?0:owner+1, grant_cnt increments (saturating at 255), state<=SCAN.
  - Otherwise stay in BUSY and increment hold_cnt.
- Latency:
  - Req sampled high at edge E in SCAN and selected: READY after E, ack high after E+1.
  - Release sampled at edge R: ack low after R.
  - The earliest next grant's READY is at R+1.
- Requests from non-owners are ignored while active=1. They are neither queued nor lost, because req stays asserted.
- req[owner] falling during READY is not seen until BUSY. In that case ack pulses for one cycle, then releases.
- sel=owner while active=1, else 0.
- grant_cnt stays at 255 once reached, with no wrap.

Optional Feature:
HOLD_TIMEOUT_EN
- Defined:
  - In BUSY, if hold_cnt reaches MAX_HOLD with req[owner] still high: ack<=0, revoked[owner]<=1, ptr<=owner+1 (mod N), state<=SCAN.
  - grant_cnt does not increment on a revoke.
  - revoked[i] clears on any edge where req[i]==0.
  - A revoked client is ineligible until its flag clears.
- Undefined:
  - No hold_cnt register. Ownership is unbounded.
  - revoked is tied to 0.

Decomposition:
- Package arb_pkg holds:
  - typedef arb_state_t {SCAN, READY, BUSY};
  - constant GRANT_CNT_MAX=255.
- One sub-module, rr_pick: combinational, inputs eligible[N] and ptr[ID_W], outputs found and idx[ID_W], implementing the wrap-around first-set search.

Test Plan:
- Reset, then req[2] high at cycle 1 → active=1 at cycle 2, ack=0000100 at cycle 3, sel=2; drop req[2] at cycle 5 → ack=0 at cycle 6, grant_cnt=1, ptr=3.
- All 7 req held high and each client releases 2 cycles after its ack → grants in order 0,1,2,3,4,5,6,0; ack never has more than one bit set.
- ptr=3 with req[1] and req[5] rising together → 5 granted first, 1 granted after 5 releases.
- rst asserted while ack[4]=1 → ack=0, active=0, grant_cnt=0 in the same cycle (asynchronous); after deassertion with req[4] still high, 4 is granted again from ptr=0.
- Force 300 single-cycle grants → grant_cnt holds at 255.
- With HOLD_TIMEOUT_EN and MAX_HOLD=15: req[0] held 40 cycles → ack[0] drops 15 BUSY cycles after ack rose, revoked[0]=1, req[3] is then granted; revoked[0] clears once req[0]=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin token arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    SCAN,
    READY,
    BUSY
  } arb_state_t;

  localparam logic [7:0] GRANT_CNT_MAX = 8'd255;

endpackage

// File: rtl/rr_pick.sv
// Wrap-around first-set search starting at ptr; purely combinational, zero latency.
module rr_pick #(
  parameter int N    = 7,
  parameter int ID_W = 3
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] ptr,
  output logic            found,
  output logic [ID_W-1:0] idx
);

  logic [ID_W:0] cand;

  // Walk offsets from farthest to nearest so the client closest to ptr wins last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (ID_W + 1)'(k);
      if (cand >= (ID_W + 1)'(N)) begin
        cand = cand - (ID_W + 1)'(N);
      end
      if (eligible[cand[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_token_arbiter.sv
// Round-robin req/ack arbiter: READY one edge after a sampled request, ack the edge after; one owner at a time,
// losers simply keep req high. HOLD_TIMEOUT_EN adds a forced revoke after MAX_HOLD busy cycles.
module rr_token_arbiter #(
  parameter int N        = 7,
  parameter int ID_W     = 3,
  parameter int MAX_HOLD = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    ack,
  output logic [ID_W-1:0] sel,
  output logic            active,
  output logic [7:0]      grant_cnt,
  output logic [N-1:0]    revoked
);
  import arb_pkg::*;

  if (N < 2 || N > 16 || (2 ** ID_W) < N || MAX_HOLD < 1) begin : g_bad_params
    $error("rr_token_arbiter: illegal parameter combination");
  end

  localparam logic [ID_W-1:0] LAST = ID_W'(N - 1);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [N-1:0]    ack_q, ack_d;
  logic [7:0]      gcnt_q, gcnt_d;
  logic [N-1:0]    eligible;
  logic [ID_W-1:0] ptr_after;
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;

`ifdef HOLD_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [N-1:0]      revoked_q, revoked_d;

  assign hold_inc = hold_q + HOLD_W'(1);
  assign eligible = req & ~revoked_q;
  assign revoked  = revoked_q;
`else
  assign eligible = req;
  assign revoked  = '0;
`endif

  assign ptr_after = (owner_q == LAST) ? '0 : owner_q + ID_W'(1);

  rr_pick #(
    .N    (N),
    .ID_W (ID_W)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    ack_d   = ack_q;
    gcnt_d  = gcnt_q;
`ifdef HOLD_TIMEOUT_EN
    hold_d    = hold_q;
    // A flag only survives while its client keeps requesting.
    revoked_d = revoked_q & req;
`endif
    case (state_q)
      SCAN: begin
        if (pick_found) begin
          owner_d = pick_idx;
          state_d = READY;
        end
      end
      READY: begin
        ack_d          = '0;
        ack_d[owner_q] = 1'b1;
`ifdef HOLD_TIMEOUT_EN
        hold_d = '0;
`endif
        state_d = BUSY;
      end
      BUSY: begin
        if (!req[owner_q]) begin
          ack_d   = '0;
          ptr_d   = ptr_after;
          state_d = SCAN;
          if (gcnt_q != GRANT_CNT_MAX) begin
            gcnt_d = gcnt_q + 8'd1;
          end
        end
`ifdef HOLD_TIMEOUT_EN
        else if (hold_inc == HOLD_W'(MAX_HOLD)) begin
          ack_d              = '0;
          revoked_d[owner_q] = 1'b1;
          ptr_d              = ptr_after;
          state_d            = SCAN;
        end else begin
          hold_d = hold_inc;
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      ptr_q   <= '0;
      owner_q <= '0;
      ack_q   <= '0;
      gcnt_q  <= '0;
`ifdef HOLD_TIMEOUT_EN
      hold_q    <= '0;
      revoked_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
      gcnt_q  <= gcnt_d;
`ifdef HOLD_TIMEOUT_EN
      hold_q    <= hold_d;
      revoked_q <= revoked_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign active    = (state_q != SCAN);
  assign sel       = active ? owner_q : '0;
  assign grant_cnt = gcnt_q;

endmodule
